fifo_sync_param: RTL

Parametrised single-clock FIFO for the iCE40 designs; successor to the fixed 8-bit RAM FIFO.
- Generalised data width and power-of-two depth.
- Selectable read mode: standard or first-word-fall-through (FWFT).
- Adds almost-full/almost-empty thresholds, a fill-level output and sticky overflow/underflow error flags.
- Sits between byte/word producers (UART RX, ADC sampler) and consumers (command parser, SPI/UART TX).

---
 rtl/fifo_sync_param_pkg.sv | 12 +
 rtl/fifo_sync_param_if.sv | 31 +++
 rtl/fifo_sync_param_ram_sdp.sv | 26 ++
 rtl/fifo_sync_param.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fifo_sync_param_pkg.sv
// Shared types and constants for the parametrised synchronous FIFO.
package fifo_sync_param_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_VALID = 1'b1
  } fwft_state_e;

  localparam int unsigned FIFO_STD  = 0;
  localparam int unsigned FIFO_FWFT = 1;

endpackage

// File: rtl/fifo_sync_param_if.sv
// Write/read handshake, status and error bundle of fifo_sync_param.
interface fifo_sync_param_if #(
  parameter int unsigned pDataWidth = 8,
  parameter int unsigned pAddrWidth = 9
);
  logic                  iWrEn;
  logic [pDataWidth-1:0] iWrData;
  logic                  oWrFull;
  logic                  oWrAlmostFull;
  logic                  iRdEn;
  logic [pDataWidth-1:0] oRdData;
  logic                  oRdValid;
  logic                  oRdEmpty;
  logic                  oRdAlmostEmpty;
  logic [pAddrWidth:0]   oCount;
  logic                  oOverflow;
  logic                  oUnderflow;
  logic                  iClrErr;

  modport master (
    output iWrEn, iWrData, iRdEn, iClrErr,
    input  oWrFull, oWrAlmostFull, oRdData, oRdValid, oRdEmpty,
           oRdAlmostEmpty, oCount, oOverflow, oUnderflow
  );

  modport slave (
    input  iWrEn, iWrData, iRdEn, iClrErr,
    output oWrFull, oWrAlmostFull, oRdData, oRdValid, oRdEmpty,
           oRdAlmostEmpty, oCount, oOverflow, oUnderflow
  );
endinterface

// File: rtl/fifo_sync_param_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// Maps onto iCE40 block RAM tiles or an inferred array.
module fifo_sync_param_ram_sdp #(
  parameter int unsigned pDataWidth = 8,
  parameter int unsigned pAddrWidth = 9
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [pAddrWidth-1:0] i_waddr,
  input  logic [pDataWidth-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [pAddrWidth-1:0] i_raddr,
  output logic [pDataWidth-1:0] o_rdata
);
  localparam int unsigned DEPTH = 1 << pAddrWidth;

  logic [pDataWidth-1:0] r_mem [DEPTH];
  logic [pDataWidth-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// almost-full/empty thresholds, fill level and sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned pDataWidth   = 8,
  parameter int unsigned pAddrWidth   = 9,
  parameter int unsigned pAlmostFull  = (1 << pAddrWidth) - 2,
  parameter int unsigned pAlmostEmpty = 2,
  parameter int unsigned pFwft        = FIFO_STD
) (
  input logic              iClk,
  input logic              iRst,
  fifo_sync_param_if.slave bus
);
  localparam int unsigned CW    = pAddrWidth + 1;
  localparam int unsigned DEPTH = 1 << pAddrWidth;
  localparam bit          FWFT  = (pFwft == FIFO_FWFT);

  if (pDataWidth == 0 || pDataWidth > 32 || pAddrWidth == 0 || pAddrWidth > 9 ||
      pFwft > 1 || pAlmostFull > DEPTH || pAlmostEmpty > DEPTH) begin : g_bad_param
    $error("fifo_sync_param: parameter out of range");
  end

  logic [CW-1:0]         r_wr_ptr, r_rd_ptr, r_count;
  logic                  r_full, r_afull, r_empty, r_aempty, r_valid;
  logic                  r_ovf, r_udf, r_pf, r_rd_issue;
  fwft_state_e           r_state, w_state_nxt;
  logic [pDataWidth-1:0] w_ram_q, r_rd_data;
  logic                  w_wr_acc, w_wr_rej, w_rd_rej, w_pop, w_slot, w_load;
  logic                  w_ram_rd, w_pf_nxt, w_empty_nxt, w_valid_nxt, w_out_ld;
  logic [CW-1:0]         w_wr_ptr_nxt, w_rd_ptr_nxt, w_ram_cnt, w_ram_cnt_nxt, w_cnt_nxt;

  assign w_wr_acc  = bus.iWrEn & ~r_full;
  assign w_wr_rej  = bus.iWrEn & r_full;
  assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
  assign w_out_ld  = FWFT ? w_load : r_rd_issue;

  // Read-side control; in FWFT mode the RAM output register acts as a one-word
  // prefetch stage ahead of the presented word, so pops run without bubbles.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_slot      = 1'b0;
    w_load      = 1'b0;
    w_ram_rd    = 1'b0;
    w_pf_nxt    = 1'b0;
    w_rd_rej    = 1'b0;
    if (FWFT) begin
      w_pop    = bus.iRdEn & (r_state == ST_VALID);
      w_rd_rej = bus.iRdEn & (r_state == ST_EMPTY);
      w_slot   = (r_state == ST_EMPTY) | w_pop;
      w_load   = w_slot & r_pf;
      w_ram_rd = (w_ram_cnt != '0) & (~r_pf | w_slot);
      w_pf_nxt = w_ram_rd | (r_pf & ~w_slot);
      case (r_state)
        ST_EMPTY: if (r_pf) w_state_nxt = ST_VALID;
        ST_VALID: if (w_pop & ~r_pf) w_state_nxt = ST_EMPTY;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end else begin
      w_ram_rd = bus.iRdEn & ~r_empty;
      w_rd_rej = bus.iRdEn & r_empty;
    end
    w_wr_ptr_nxt  = r_wr_ptr + CW'(w_wr_acc);
    w_rd_ptr_nxt  = r_rd_ptr + CW'(w_ram_rd);
    w_ram_cnt_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
    w_cnt_nxt     = w_ram_cnt_nxt;
    if (FWFT) w_cnt_nxt = w_ram_cnt_nxt + CW'(w_state_nxt == ST_VALID) + CW'(w_pf_nxt);
    w_empty_nxt = FWFT ? (w_state_nxt == ST_EMPTY) : (w_ram_cnt_nxt == '0);
    w_valid_nxt = FWFT ? (w_state_nxt == ST_VALID) : r_rd_issue;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) r_state <= ST_EMPTY;
    else      r_state <= w_state_nxt;
  end

  // Pointers, occupancy and all status flags reflect the state after this edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_empty    <= 1'b1;
      r_aempty   <= 1'b1;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_udf      <= 1'b0;
      r_pf       <= 1'b0;
      r_rd_issue <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_count    <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == CW'(DEPTH));
      r_afull    <= (w_cnt_nxt >= CW'(pAlmostFull));
      r_empty    <= w_empty_nxt;
      r_aempty   <= (w_cnt_nxt <= CW'(pAlmostEmpty));
      r_valid    <= w_valid_nxt;
      r_pf       <= w_pf_nxt;
      r_rd_issue <= w_ram_rd & ~FWFT;
      if (bus.iClrErr) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        r_ovf <= r_ovf | w_wr_rej;
        r_udf <= r_udf | w_rd_rej;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (w_out_ld) r_rd_data <= w_ram_q;
  end

  fifo_sync_param_ram_sdp #(
    .pDataWidth(pDataWidth),
    .pAddrWidth(pAddrWidth)
  ) u_ram (
    .i_clk   (iClk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[pAddrWidth-1:0]),
    .i_wdata (bus.iWrData),
    .i_re    (w_ram_rd),
    .i_raddr (r_rd_ptr[pAddrWidth-1:0]),
    .o_rdata (w_ram_q)
  );

  assign bus.oWrFull        = r_full;
  assign bus.oWrAlmostFull  = r_afull;
  assign bus.oRdData        = r_rd_data;
  assign bus.oRdValid       = r_valid;
  assign bus.oRdEmpty       = r_empty;
  assign bus.oRdAlmostEmpty = r_aempty;
  assign bus.oCount         = r_count;
  assign bus.oOverflow      = r_ovf;
  assign bus.oUnderflow     = r_udf;
endmodule
